// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed USB transmit line encoder.
// Takes a byte stream and drives the D+/D- pad mux. It sends SYNC, NRZI-encodes
// the data LSB first with bit stuffing, and finishes with EOP.
// Each bit occupies CLKS_PER_BIT core clocks.
//
// Ports:
//   clk, reset       core clock; synchronous active-high reset
//   tx_pkt_start     1-cycle pulse that starts a packet (honoured only when idle)
//   tx_data          byte to send
//   tx_data_valid    qualifies tx_data and tx_data_last
//   tx_data_last     marks the final byte of the packet
//   tx_data_ready    byte taken this cycle when tx_data_valid is also high
//   tx_busy          packet in progress
//   tx_underrun      pulse: a byte was needed but tx_data_valid was low
//   oe, dp_tx, dn_tx drive enable and D+/D- levels to the pad mux
//
// Build option: define USB_FS_TX_UNDERRUN_ABORT_EN to send 8 held bit times
// (a forced stuff error) on underrun before EOP. Without it, an underrun goes
// straight to EOP.
module usb_fs_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_pkt_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_data_last,
  output logic       tx_data_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       oe,
  output logic       dp_tx,
  output logic       dn_tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_ABORT,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;    // data bit on the line (or last data bit, during a stuff bit)
  logic [2:0]      ones;       // consecutive 1s, including the bit on the line
  logic [7:0]      shift;
  logic            last_q;
  logic            cur_stuff;  // the bit on the line is a stuffed 0
  logic            lvl;        // NRZI level: 1 = J, 0 = K

  logic            at_bit_end;
  logic            in_stream;
  logic            stuff_due;
  logic [2:0]      nxt_idx;
  logic            nxt_bit;

  assign at_bit_end    = (timer == T_LAST);
  assign in_stream     = (state == ST_SYNC) || (state == ST_DATA);
  assign stuff_due     = !cur_stuff && (ones == 3'd6);
  assign nxt_idx       = bit_idx + 3'd1;
  // The fetch cycle is the last clock of bit 7. It moves to the end of the
  // stuff bit when a stuff bit follows bit 7.
  assign tx_data_ready = in_stream && at_bit_end && (bit_idx == 3'd7) && !stuff_due && !last_q;
  assign tx_underrun   = tx_data_ready && !tx_data_valid;

  always_comb begin
    nxt_bit = shift[nxt_idx];
    if (bit_idx == 3'd7) nxt_bit = tx_data[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      ones      <= '0;
      shift     <= '0;
      last_q    <= 1'b0;
      cur_stuff <= 1'b0;
      lvl       <= 1'b1;
      oe        <= 1'b0;
      tx_busy   <= 1'b0;
      dp_tx     <= 1'b1;
      dn_tx     <= 1'b0;
    end else begin
      if (state != ST_IDLE) timer <= at_bit_end ? '0 : timer + TW'(1);

      case (state)
        ST_IDLE: begin
          if (tx_pkt_start) begin
            // SYNC begins with a 0 bit, so the first symbol toggles J -> K.
            state     <= ST_SYNC;
            timer     <= '0;
            bit_idx   <= '0;
            ones      <= '0;
            shift     <= 8'h80;
            last_q    <= 1'b0;
            cur_stuff <= 1'b0;
            lvl       <= 1'b0;
            oe        <= 1'b1;
            tx_busy   <= 1'b1;
            dp_tx     <= 1'b0;
            dn_tx     <= 1'b1;
          end
        end

        ST_SYNC, ST_DATA: begin
          if (at_bit_end) begin
            if (stuff_due) begin
              lvl       <= ~lvl;
              dp_tx     <= ~lvl;
              dn_tx     <= lvl;
              ones      <= '0;
              cur_stuff <= 1'b1;
            end else if ((bit_idx != 3'd7) || (!last_q && tx_data_valid)) begin
              if (bit_idx == 3'd7) begin
                shift   <= tx_data;
                last_q  <= tx_data_last;
                bit_idx <= '0;
                state   <= ST_DATA;
              end else begin
                bit_idx <= nxt_idx;
              end
              cur_stuff <= 1'b0;
              if (!nxt_bit) begin
                lvl   <= ~lvl;
                dp_tx <= ~lvl;
                dn_tx <= lvl;
                ones  <= '0;
              end else begin
                ones  <= ones + 3'd1;
              end
            end else if (last_q) begin
              state   <= ST_EOP_SE0;
              bit_idx <= '0;
              dp_tx   <= 1'b0;
              dn_tx   <= 1'b0;
            end else begin
`ifdef USB_FS_TX_UNDERRUN_ABORT_EN
              state     <= ST_ABORT;
              bit_idx   <= '0;
              cur_stuff <= 1'b0;
`else
              state   <= ST_EOP_SE0;
              bit_idx <= '0;
              dp_tx   <= 1'b0;
              dn_tx   <= 1'b0;
`endif
            end
          end
        end

        ST_ABORT: begin
          // The line level is held for 8 bit times with no stuffing.
          if (at_bit_end) begin
            if (bit_idx == 3'd7) begin
              state   <= ST_EOP_SE0;
              bit_idx <= '0;
              dp_tx   <= 1'b0;
              dn_tx   <= 1'b0;
            end else begin
              bit_idx <= nxt_idx;
            end
          end
        end

        ST_EOP_SE0: begin
          if (at_bit_end) begin
            if (bit_idx == 3'd1) begin
              state <= ST_EOP_J;
              lvl   <= 1'b1;
              dp_tx <= 1'b1;
              dn_tx <= 1'b0;
            end else begin
              bit_idx <= nxt_idx;
            end
          end
        end

        ST_EOP_J: begin
          if (at_bit_end) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            ones    <= '0;
            oe      <= 1'b0;
            tx_busy <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_tx.sv
module tb_usb_fs_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_pkt_start;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_last;
  logic       tx_data_ready;
  logic       tx_busy;
  logic       tx_underrun;
  logic       oe;
  logic       dp_tx;
  logic       dn_tx;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected line symbols ({dp,dn}) per bit time, and the
  // expected cycles (counted from the start edge) of ready and underrun pulses.
  logic [1:0] sym_q[$];
  int         rdy_q[$];
  int         und_q[$];

  logic m_lvl;
  int   m_ones;
  int   m_nb;

  usb_fs_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_pkt_start (tx_pkt_start),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_last (tx_data_last),
    .tx_data_ready(tx_data_ready),
    .tx_busy      (tx_busy),
    .tx_underrun  (tx_underrun),
    .oe           (oe),
    .dp_tx        (dp_tx),
    .dn_tx        (dn_tx)
  );

  always #5 clk = ~clk;

  task automatic model_bit(input logic b);
    if (!b) begin
      m_lvl  = ~m_lvl;
      m_ones = 0;
    end else begin
      m_ones++;
    end
    sym_q.push_back({m_lvl, ~m_lvl});
    m_nb++;
    if (m_ones == 6) begin
      m_lvl  = ~m_lvl;
      m_ones = 0;
      sym_q.push_back({m_lvl, ~m_lvl});
      m_nb++;
    end
  endtask

  task automatic build_model(input logic [23:0] pkt, input int n, input int und_at);
    logic [7:0] sync_b;
    logic [7:0] by;
    sym_q.delete(); rdy_q.delete(); und_q.delete();
    m_lvl = 1'b1; m_ones = 0; m_nb = 0;
    sync_b = 8'h80;
    for (int i = 0; i < 8; i++) model_bit(sync_b[i]);
    for (int fi = 0; fi < n; fi++) begin
      rdy_q.push_back(m_nb * CPB);
      if (fi == und_at) begin
        und_q.push_back(m_nb * CPB);
`ifdef USB_FS_TX_UNDERRUN_ABORT_EN
        for (int k = 0; k < 8; k++) sym_q.push_back({m_lvl, ~m_lvl});
`endif
        break;
      end
      by = pkt[8*fi +: 8];
      for (int i = 0; i < 8; i++) model_bit(by[i]);
    end
    sym_q.push_back(2'b00);
    sym_q.push_back(2'b00);
    sym_q.push_back(2'b10);
  endtask

  // Call this away from a clock edge, with the DUT idle. It returns during
  // the first idle cycle after the packet.
  task automatic run_packet(input string name, input logic [23:0] pkt, input int n,
                            input int und_at, input int pulse_at);
    int c, fi, oe_cycles, exp_cycles, bound, bi;
    logic acc;
    logic [1:0] got, expv;
    int e;
    build_model(pkt, n, und_at);
    exp_cycles = sym_q.size() * CPB;
    bound = exp_cycles + 8;
    fi = 0;
    tx_data = pkt[7:0];
    tx_data_last = (n == 1);
    tx_data_valid = (und_at != 0);
    tx_pkt_start = 1'b1;
    @(posedge clk); #1 tx_pkt_start = 1'b0; #1;
    c = 1; oe_cycles = 0; acc = 1'b0; bi = 0;
    checks++;
    if (oe !== 1'b1) begin
      errors++;
      $display("FAIL %s start_accept: oe=%b required 1", name, oe);
    end
    while (oe === 1'b1 && c <= bound) begin
      oe_cycles++;
      if ((c - 1) % CPB == 0) begin
        got = {dp_tx, dn_tx};
        checks++;
        if (sym_q.size() == 0) begin
          errors++;
          $display("FAIL %s sym[%0d]: got %b, no symbol expected", name, bi, got);
        end else begin
          expv = sym_q.pop_front();
          if (got !== expv) begin
            errors++;
            $display("FAIL %s sym[%0d]: got %b required %b", name, bi, got, expv);
          end
        end
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy[%0d]: got %b required 1", name, bi, tx_busy);
        end
        bi++;
      end
      acc = 1'b0;
      if (tx_data_ready === 1'b1) begin
        checks++;
        if (rdy_q.size() == 0) begin
          errors++;
          $display("FAIL %s ready: unexpected pulse at cycle %0d", name, c);
        end else begin
          e = rdy_q.pop_front();
          if (c != e) begin
            errors++;
            $display("FAIL %s ready: pulse at cycle %0d required %0d", name, c, e);
          end
        end
        acc = tx_data_valid;
      end
      if (tx_underrun === 1'b1) begin
        checks++;
        if (und_q.size() == 0) begin
          errors++;
          $display("FAIL %s underrun: unexpected pulse at cycle %0d", name, c);
        end else begin
          e = und_q.pop_front();
          if (c != e) begin
            errors++;
            $display("FAIL %s underrun: pulse at cycle %0d required %0d", name, c, e);
          end
        end
      end
      if (c == pulse_at) tx_pkt_start = 1'b1;
      @(posedge clk); #1;
      tx_pkt_start = 1'b0;
      if (acc) begin
        fi++;
        if (fi < n) begin
          tx_data = pkt[8*fi +: 8];
          tx_data_last = (fi == n - 1);
          tx_data_valid = (fi != und_at);
        end else begin
          tx_data_valid = 1'b0;
          tx_data_last = 1'b0;
        end
      end
      #1;
      c++;
    end
    checks++;
    if (oe_cycles != exp_cycles) begin
      errors++;
      $display("FAIL %s oe_len: got %0d cycles required %0d", name, oe_cycles, exp_cycles);
    end
    checks++;
    if (sym_q.size() != 0 || rdy_q.size() != 0 || und_q.size() != 0) begin
      errors++;
      $display("FAIL %s leftover: sym=%0d ready=%0d underrun=%0d required 0 0 0",
               name, sym_q.size(), rdy_q.size(), und_q.size());
    end
    checks++;
    if ({oe, dp_tx, dn_tx, tx_busy, tx_data_ready, tx_underrun} !== 6'b010000) begin
      errors++;
      $display("FAIL %s idle_after: oe,dp,dn,busy,rdy,und=%b required 010000", name,
               {oe, dp_tx, dn_tx, tx_busy, tx_data_ready, tx_underrun});
    end
    tx_data_valid = 1'b0;
    tx_data_last = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_pkt_start = 1'b0; tx_data = '0; tx_data_valid = 1'b0; tx_data_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({oe, dp_tx, dn_tx, tx_busy, tx_data_ready, tx_underrun} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_state: oe,dp,dn,busy,rdy,und=%b required 010000",
               {oe, dp_tx, dn_tx, tx_busy, tx_data_ready, tx_underrun});
    end
  endtask

  task automatic test_single_byte();
    run_packet("byte_c3", 24'h0000C3, 1, -1, 0);
  endtask

  task automatic test_stuffing();
    run_packet("byte_ff", 24'h0000FF, 1, -1, 0);
    run_packet("stuff_fetch", 24'h0001FC, 2, -1, 0);
    run_packet("stuff_last", 24'h0000FC, 1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_packet("three_bytes", 24'h030201, 3, -1, 0);
  endtask

  task automatic test_underrun();
    run_packet("underrun_2nd", 24'h332211, 3, 1, 0);
    run_packet("underrun_1st", 24'h000055, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    tx_data = 8'hAA; tx_data_valid = 1'b1; tx_data_last = 1'b0;
    tx_pkt_start = 1'b1;
    @(posedge clk); #1 tx_pkt_start = 1'b0;
    repeat (44) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    tx_data_valid = 1'b0;
    checks++;
    if ({oe, dp_tx, dn_tx, tx_busy, tx_data_ready, tx_underrun} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_mid: oe,dp,dn,busy,rdy,und=%b required 010000",
               {oe, dp_tx, dn_tx, tx_busy, tx_data_ready, tx_underrun});
    end
    run_packet("after_reset", 24'h0000C3, 1, -1, 0);
  endtask

  task automatic test_start_while_busy();
    run_packet("start_ignored", 24'h0000C3, 1, -1, 40);
    run_packet("idle_restart", 24'h00A55A, 2, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuffing();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
